// File: rtl/gcd_result_buffer.sv
// Result buffer behind the GCD core: acks each result, queues it in a
// small FIFO and replays it on a valid/ready stream to the next stage.
module gcd_result_buffer #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gcd_valid,
    input  logic [W-1:0]             gcd_out,
    output logic                     ack_rcvd,
    output logic                     res_valid,
    output logic [W-1:0]             res_data,
    input  logic                     res_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [CNT_W-1:0]         total_results
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Capture FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Capture only from IDLE with room; ACK always lasts one cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (gcd_valid && !full) state_nxt = ACK;
            ACK:  state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ack is a decode of the state register, push is the capture
    always_comb begin
        ack_rcvd = (state == ACK);
        push     = (state == IDLE) && gcd_valid && !full;
    end

    assign res_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = res_valid && res_ready;
    assign res_data  = res_valid ? mem[rd_ptr] : '0;

    // FIFO storage and pointers; occupancy is tracked by count, not pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= gcd_out;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Running tally of captured results, sticking at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_results <= '0;
        end else if (push && (total_results != '1)) begin
            total_results <= total_results + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gcd_result_buffer.sv
// Scoreboard bench for gcd_result_buffer: directed scenarios followed by
// random offers and random sink stalls against a queue-based model.
module tb_gcd_result_buffer;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   reset;
    logic                   gcd_valid;
    logic [W-1:0]           gcd_out;
    logic                   ack_rcvd;
    logic                   res_valid;
    logic [W-1:0]           res_data;
    logic                   res_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic [CNT_W-1:0]       total_results;

    int n_chk  = 0;
    int n_pass = 0;

    int m_q[$];
    bit m_ack = 0;
    int m_tot = 0;

    gcd_result_buffer #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gcd_valid     (gcd_valid),
        .gcd_out       (gcd_out),
        .ack_rcvd      (ack_rcvd),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_ready     (res_ready),
        .count         (count),
        .full          (full),
        .total_results (total_results)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: sample inputs mid-cycle, check outputs, predict next edge
    always @(negedge clk) begin
        bit cap;
        bit pop;
        if (reset) begin
            m_q.delete();
            m_ack = 1'b0;
            m_tot = 0;
        end else begin
            chk("ack", int'(ack_rcvd), int'(m_ack));
            chk("count", int'(count), m_q.size());
            chk("full", int'(full), int'(m_q.size() == DEPTH));
            chk("valid", int'(res_valid), int'(m_q.size() != 0));
            chk("total", int'(total_results), m_tot);
            pop = res_ready && (m_q.size() != 0);
            cap = !m_ack && gcd_valid && (m_q.size() < DEPTH);
            if (pop) begin
                chk("data", int'(res_data), m_q[0]);
                void'(m_q.pop_front());
            end
            if (cap) begin
                m_q.push_back(int'(gcd_out));
                if (m_tot < SAT) m_tot++;
            end
            m_ack = cap;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            step();
            n++;
        end while (!ack_rcvd && n < 40);
        if (!ack_rcvd) chk("ack_timeout", int'(ack_rcvd), 1);
    endtask

    task automatic offer(input logic [W-1:0] v, input bit keep);
        gcd_out   = v;
        gcd_valid = 1'b1;
        wait_ack();
        if (!keep) gcd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        res_ready = 1'b1;
        while (m_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (m_q.size() != 0) chk("drain_timeout", int'(count), 0);
        res_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        gcd_valid = 1'b0;
        gcd_out   = '0;
        res_ready = 1'b0;
        repeat (2) step();
        chk("rst_ack", int'(ack_rcvd), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_data", int'(res_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_total", int'(total_results), 0);
        reset = 1'b0;
        step();

        // single result
        offer(8'd6, 1'b0);
        chk("single_valid", int'(res_valid), 1);
        chk("single_data", int'(res_data), 6);
        chk("single_total", int'(total_results), 1);
        step();
        chk("single_ack_once", int'(ack_rcvd), 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("single_empty", int'(count), 0);

        // fill and stall
        offer(8'd12, 1'b0);
        offer(8'd4, 1'b0);
        offer(8'd9, 1'b0);
        offer(8'd21, 1'b0);
        step();
        chk("fill_full", int'(full), 1);
        gcd_out   = 8'd7;
        gcd_valid = 1'b1;
        repeat (10) step();
        chk("stall_noack", int'(ack_rcvd), 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("pop_same_cycle_noack", int'(ack_rcvd), 0);
        step();
        chk("ack_after_pop", int'(ack_rcvd), 1);
        gcd_valid = 1'b0;
        chk("stall_head", int'(res_data), 4);
        drain();

        // back-to-back offers with valid held
        offer(8'd3, 1'b1);
        offer(8'd5, 1'b0);
        step();
        chk("b2b_count", int'(count), 2);
        drain();

        // simultaneous push and pop at count 2
        offer(8'd10, 1'b0);
        offer(8'd11, 1'b0);
        step();
        gcd_out   = 8'd13;
        gcd_valid = 1'b1;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        gcd_valid = 1'b0;
        chk("pp_ack", int'(ack_rcvd), 1);
        chk("pp_count", int'(count), 2);
        chk("pp_head", int'(res_data), 11);
        drain();

        // asynchronous reset while ack is high
        offer(8'd20, 1'b0);
        offer(8'd21, 1'b0);
        gcd_out   = 8'd22;
        gcd_valid = 1'b1;
        wait_ack();
        chk("pre_rst_count", int'(count), 3);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_ack", int'(ack_rcvd), 0);
        chk("mid_rst_valid", int'(res_valid), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_total", int'(total_results), 0);
        gcd_out = 8'd2;
        step();
        reset = 1'b0;
        wait_ack();
        gcd_valid = 1'b0;
        chk("post_rst_data", int'(res_data), 2);
        chk("post_rst_total", int'(total_results), 1);
        drain();

        // total_results saturation with continuous draining
        reset = 1'b1;
        step();
        reset = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            offer(W'(i + 30), 1'b0);
            if (i == 6) chk("sat_at_7", int'(total_results), SAT);
        end
        step();
        chk("sat_hold", int'(total_results), SAT);
        drain();

        // random offers against a random sink
        for (int i = 0; i < 600; i++) begin
            if (i < 300) res_ready = ($urandom_range(0, 3) != 0);
            else         res_ready = ($urandom_range(0, 3) == 0);
            if (!gcd_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    gcd_valid = 1'b1;
                    gcd_out   = W'($urandom);
                end
            end else if (ack_rcvd) begin
                if ($urandom_range(0, 1) == 0) gcd_out = W'($urandom);
                else                           gcd_valid = 1'b0;
            end
            step();
        end
        gcd_valid = 1'b0;
        step();
        step();
        drain();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gcd_result_buffer.md
Name: gcd_result_buffer

Overview:
Downstream consumer of the GCD core's result port.
- Accepts each result offered on gcd_valid/gcd_out and acknowledges it with a one-cycle ack_rcvd pulse.
- Queues results in a small FIFO and re-presents them on a valid/ready stream to the next stage.
- Decouples the GCD core from a slow or stalling sink and keeps a running count of results consumed.

Parameters:
- W, 8, width of gcd_out and res_data (matches GCD operand width).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the total_results counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- gcd_valid  input  1  GCD core result valid; held high until acknowledged.
- gcd_out  input  W  GCD result value.
- ack_rcvd  output  1  registered one-cycle acknowledge to the GCD core.
- res_valid  output  1  FIFO head valid.
- res_data  output  W  FIFO head value.
- res_ready  input  1  sink accepts head.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- full  output  1  count == DEPTH.
- total_results  output  CNT_W  results captured since reset; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. All state clears immediately on reset assertion, independent of clk.
- Reset values: ack_rcvd=0, res_valid=0, res_data=0, count=0, full=0, total_results=0, FSM in IDLE, FIFO pointers 0.
- Capture FSM has two states, IDLE and ACK.
  - IDLE: if gcd_valid=1 and full=0 at the clock edge, then write gcd_out into the FIFO tail, increment total_results (saturating), set ack_rcvd=1, and go to ACK. Otherwise stay in IDLE with ack_rcvd=0.
  - ACK: ack_rcvd=1 for exactly this cycle. gcd_valid is ignored, because the core deasserts valid after seeing the ack. Unconditionally return to IDLE, and ack_rcvd=0 next cycle.
  - Result: at most one capture every 2 cycles. Each capture produces exactly one ack_rcvd pulse. No result is captured twice.
- Capture latency: result sampled at edge N, ack_rcvd high during cycle N..N+1, and res_valid high from edge N if the FIFO was empty (registered count/valid update at the same edge).
- Back-pressure:
  - When full=1, the FSM stays in IDLE and withholds ack_rcvd. gcd_valid stays pending in the core and no data is lost.
  - The full test uses the registered count. A pop in the same cycle does not enable a capture; the capture happens one cycle later.
- Output stream:
  - res_valid = (count != 0).
  - res_data = FIFO head. It is a registered/array read of the head pointer and is stable while res_valid=1 and res_ready=0.
  - A pop occurs when res_valid && res_ready at the edge; the head pointer advances.
  - res_ready while empty has no effect.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any occupancy 1..DEPTH-1.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The count is used for full/empty, not pointer compare.
- total_results stops at 2^CNT_W-1 and never wraps.
- Reset mid-operation:
  - Reset during ACK drops ack_rcvd immediately.
  - FIFO contents are discarded and count=0.
  - A gcd_valid still high after reset release is captured at the first edge with reset low, as a new result.
- gcd_out is sampled only on the capture edge. Changes at other times are ignored.

Test Plan:
- Single result: reset, then gcd_valid=1, gcd_out=8'd6 held until ack. Required: ack_rcvd high exactly 1 cycle, next edge res_valid=1, res_data=6, count=1, total_results=1. With res_ready=1, the next edge gives res_valid=0 and count=0.
- Fill and stall: res_ready=0, offer 12, 4, 9, 21 each held until acked. Required: count=4, full=1. A fifth result 7 gets no ack for 10 cycles. Then res_ready=1 for one cycle pops 12; 7 is acked one cycle later (not the same cycle). Drain order is 4, 9, 21, 7.
- Back-to-back offer: gcd_valid held continuously with gcd_out changing 3 then 5 immediately after each ack. Required: captures exactly 2 cycles apart, ack_rcvd pattern 1,0,1,0, FIFO holds 3, 5 with no duplicate.
- Simultaneous push/pop at count=2 (heads 10, 11), capturing 13 while popping 10. Required: count stays 2, head becomes 11, next pops give 11 then 13. Pointer wrap is exercised after 6 total pushes with DEPTH=4.
- Reset mid-ACK: assert reset asynchronously mid-cycle while ack_rcvd=1 with count=3. Required: ack_rcvd, res_valid, count and total_results go to 0 before the next edge. A held gcd_valid with gcd_out=2 is captured on the first edge after release.
- Saturation with CNT_W=3: push 9 results, draining continuously. Required: total_results reads 7 after the 7th capture and stays 7.
